axis_flit_serializer: RTL



---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_credit_counter.sv | 43 ++++
 rtl/axis_flit_serializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: flit layout, serializer state encoding and credit counter sizing.
package noc_pkg;

    localparam int NOC_FLIT_W = 128;
    localparam int NOC_DEST_W = 6;

    typedef struct packed {
        logic [NOC_FLIT_W-1:0] data;
        logic [NOC_DEST_W-1:0] dest;
        logic                  is_tail;
    } flit_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

    // Enough bits to hold every value from 0 up to and including depth.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for a credit-based NoC link: starts full, -1 per flit sent, +1 per credit returned.
module noc_credit_counter
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = credit_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != FULL) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    // A credit returned while already full means the downstream buffer lied; saturate and flag it.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(inc_i && !dec_i && count_q == FULL))
        else $error("noc_credit_counter: credit returned while counter full");

endmodule

// File: rtl/axis_flit_serializer.sv
// AXIS beat to NoC flit serializer with credit flow control.
// Define AXIS_FLIT_SERIALIZER_TKEEP_TRIM_EN to drop empty trailing flits of a tlast beat.
module axis_flit_serializer
    import noc_pkg::*;
#(
    parameter int TDATA_WIDTH          = 512,
    parameter int DEST_WIDTH           = 6,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         axis_tvalid,
    output logic                                         axis_tready,
    input  logic [TDATA_WIDTH-1:0]                       axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]                     axis_tkeep,
    input  logic                                         axis_tlast,
    input  logic [DEST_WIDTH-1:0]                        axis_tdest,
    output logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]                        dest_out,
    output logic                                         is_tail_out,
    output logic                                         send_out,
    input  logic                                         credit_in
);

    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int KW         = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int CW         = credit_w(FLIT_BUFFER_DEPTH);
    localparam logic [KW-1:0] FULL_IDX = KW'(SERIALIZATION_FACTOR - 1);

    ser_state_e             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          last_idx_q, last_idx_d;
    logic [TDATA_WIDTH-1:0] beat_q, beat_d;
    logic [DEST_WIDTH-1:0]  bdest_q, bdest_d;
    logic                   blast_q, blast_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   tail_q, tail_d;
    logic                   send_q, send_d;

    logic [CW-1:0]          credits;
    logic [KW-1:0]          new_last_idx;
    logic                   send_now;
    logic                   at_last;
    logic                   accept;
    logic [FLIT_WIDTH-1:0]  beat_flits [SERIALIZATION_FACTOR];

    for (genvar g = 0; g < SERIALIZATION_FACTOR; g++) begin : g_split
        assign beat_flits[g] = beat_q[g*FLIT_WIDTH +: FLIT_WIDTH];
    end

`ifdef AXIS_FLIT_SERIALIZER_TKEEP_TRIM_EN
    localparam int KEEP_PER_FLIT = FLIT_WIDTH / 8;

    if (FLIT_WIDTH % 8 != 0) begin : g_bad_flit_width
        $error("axis_flit_serializer: tkeep trimming needs a byte-multiple flit width");
    end

    // Highest flit holding any kept byte; an all-empty tlast beat still yields one tail flit.
    always_comb begin
        new_last_idx = FULL_IDX;
        if (axis_tlast) begin
            new_last_idx = '0;
            for (int i = 0; i < SERIALIZATION_FACTOR; i++) begin
                if (|axis_tkeep[i*KEEP_PER_FLIT +: KEEP_PER_FLIT]) begin
                    new_last_idx = KW'(i);
                end
            end
        end
    end
`else
    logic unused_tkeep;
    assign unused_tkeep = ^axis_tkeep;
    assign new_last_idx = FULL_IDX;
`endif

    noc_credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CW)
    ) u_credit (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (credit_in),
        .dec_i   (send_now),
        .count_o (credits)
    );

    assign send_now    = (state_q == SER_SEND) && (credits != '0);
    assign at_last     = (k_q == last_idx_q);
    assign axis_tready = !rst && ((state_q == SER_IDLE) || (send_now && at_last));
    assign accept      = axis_tvalid && axis_tready;

    // NOTE: every next-state signal gets a hold default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        last_idx_d = last_idx_q;
        beat_d     = beat_q;
        bdest_d    = bdest_q;
        blast_d    = blast_q;
        data_d     = data_q;
        dest_d     = dest_q;
        tail_d     = tail_q;
        send_d     = 1'b0;

        if (send_now) begin
            data_d = beat_flits[k_q];
            dest_d = bdest_q;
            tail_d = blast_q && at_last;
            send_d = 1'b1;
            k_d    = k_q + 1'b1;
            if (at_last) begin
                state_d = SER_IDLE;
            end
        end

        // A beat accepted on the final flit's cycle overrides the return to idle.
        if (accept) begin
            beat_d     = axis_tdata;
            bdest_d    = axis_tdest;
            blast_d    = axis_tlast;
            last_idx_d = new_last_idx;
            k_d        = '0;
            state_d    = SER_SEND;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SER_IDLE;
            k_q        <= '0;
            last_idx_q <= FULL_IDX;
            beat_q     <= '0;
            bdest_q    <= '0;
            blast_q    <= 1'b0;
            data_q     <= '0;
            dest_q     <= '0;
            tail_q     <= 1'b0;
            send_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            last_idx_q <= last_idx_d;
            beat_q     <= beat_d;
            bdest_q    <= bdest_d;
            blast_q    <= blast_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            tail_q     <= tail_d;
            send_q     <= send_d;
        end
    end

    assign data_out    = data_q;
    assign dest_out    = dest_q;
    assign is_tail_out = tail_q;
    assign send_out    = send_q;

endmodule
